nibble_serial_adder_ctrl: RTL and testbench

NIBBLE_SERIAL_ADDER_CTRL -- requirements
Module: nibble_serial_adder_ctrl

---
 rtl/sum_pkg.sv | 12 +
 rtl/sum_nibble.sv | 18 +
 rtl/nibble_serial_adder_ctrl.sv | 107 ++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/sum_pkg.sv
// Shared definitions for the nibble-serial adder: nibble width and controller state encoding.
package sum_pkg;

  localparam int unsigned NibbleW = 4;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StAdd  = 2'b01,
    StDone = 2'b10
  } state_e;

endpackage

// File: rtl/sum_nibble.sv
// Combinational 4-bit adder with carry-in/carry-out, reused once per cycle by the controller.
module sum_nibble
  import sum_pkg::*;
(
  input  logic [NibbleW-1:0] i_bit1,
  input  logic [NibbleW-1:0] i_bit2,
  input  logic               i_Carry,
  output logic [NibbleW-1:0] o_Suma,
  output logic               o_Carry
);

  logic [NibbleW:0] total;

  assign total   = {1'b0, i_bit1} + {1'b0, i_bit2} + {{NibbleW{1'b0}}, i_Carry};
  assign o_Suma  = total[NibbleW-1:0];
  assign o_Carry = total[NibbleW];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Serial W-bit adder: one shared nibble adder walks the operands LSB nibble first,
// building the result register in place; IDLE -> ADD (N_NIBBLES cycles) -> DONE.
module nibble_serial_adder_ctrl
  import sum_pkg::*;
#(
  parameter  int unsigned N_NIBBLES = 4,
  localparam int unsigned W         = NibbleW * N_NIBBLES
) (
  input  logic         i_Clk,
  input  logic         i_Rst,
  input  logic         i_Start,
  input  logic [W-1:0] i_bit1,
  input  logic [W-1:0] i_bit2,
  input  logic         i_Carry,
  output logic         o_Busy,
  output logic         o_Done,
  output logic [W-1:0] o_Suma,
  output logic         o_Carry
);

  localparam int unsigned    KW    = (N_NIBBLES > 1) ? $clog2(N_NIBBLES) : 1;
  localparam logic [KW-1:0]  KLast = KW'(N_NIBBLES - 1);

  state_e         state_q, state_d;
  logic [KW-1:0]  k_q, k_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic           carry_q, carry_d;
  logic [W-1:0]   sum_q, sum_d;

  // Bit offset of nibble k is 4*k.
  logic [KW+1:0]        nib_base;
  logic [NibbleW-1:0]   nib_a, nib_b, nib_sum;
  logic                 nib_carry;

  assign nib_base = {k_q, 2'b00};
  assign nib_a    = a_q[nib_base +: NibbleW];
  assign nib_b    = b_q[nib_base +: NibbleW];

  sum_nibble u_sum_nibble (
    .i_bit1  (nib_a),
    .i_bit2  (nib_b),
    .i_Carry (carry_q),
    .o_Suma  (nib_sum),
    .o_Carry (nib_carry)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    unique case (state_q)
      StIdle: begin
        if (i_Start) begin
          state_d = StAdd;
          a_d     = i_bit1;
          b_d     = i_bit2;
          carry_d = i_Carry;
          k_d     = '0;
        end
      end
      StAdd: begin
        sum_d[nib_base +: NibbleW] = nib_sum;
        carry_d                    = nib_carry;
        k_d                        = k_q + KW'(1);
        if (k_q == KLast) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q <= StIdle;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
    end
  end

  // After the last nibble the carry register is the final carry-out and is left
  // untouched until the next accepted start.
  assign o_Busy  = (state_q == StAdd);
  assign o_Done  = (state_q == StDone);
  assign o_Suma  = sum_q;
  assign o_Carry = carry_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for nibble_serial_adder_ctrl: a 4-nibble and a 2-nibble instance checked every cycle
// against an arithmetic timeline model, plus hand-computed directed cases.
module tb_nibble_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start [2];
  logic [15:0] op_a  [2];
  logic [15:0] op_b  [2];
  logic        cin   [2];

  logic        busy4, done4, c4;
  logic [15:0] s4;
  logic        busy2, done2, c2;
  logic [7:0]  s2;

  nibble_serial_adder_ctrl #(.N_NIBBLES(4)) dut4 (
    .i_Clk   (clk),
    .i_Rst   (rst),
    .i_Start (start[0]),
    .i_bit1  (op_a[0]),
    .i_bit2  (op_b[0]),
    .i_Carry (cin[0]),
    .o_Busy  (busy4),
    .o_Done  (done4),
    .o_Suma  (s4),
    .o_Carry (c4)
  );

  nibble_serial_adder_ctrl #(.N_NIBBLES(2)) dut2 (
    .i_Clk   (clk),
    .i_Rst   (rst),
    .i_Start (start[1]),
    .i_bit1  (op_a[1][7:0]),
    .i_bit2  (op_b[1][7:0]),
    .i_Carry (cin[1]),
    .o_Busy  (busy2),
    .o_Done  (done2),
    .o_Suma  (s2),
    .o_Carry (c2)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Model: age = cycles since the accepting edge (-1 when idle); held = last completed {carry,sum}.
  int          age  [2];
  logic [16:0] pend [2];
  logic [16:0] held [2];

  function automatic int nn(input int i);
    return (i == 0) ? 4 : 2;
  endfunction

  function automatic logic [15:0] msk(input int i);
    return (i == 0) ? 16'hFFFF : 16'h00FF;
  endfunction

  function automatic logic [16:0] opsum(input int i);
    return {1'b0, op_a[i] & msk(i)} + {1'b0, op_b[i] & msk(i)} + 17'(cin[i]);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        age[i]  <= -1;
        held[i] <= '0;
        pend[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (age[i] < 0) begin
          if (start[i]) begin
            age[i]  <= 0;
            pend[i] <= opsum(i);
          end
        end else if (age[i] == nn(i)) begin
          age[i] <= -1;
        end else begin
          age[i] <= age[i] + 1;
          if (age[i] + 1 == nn(i)) held[i] <= pend[i];
        end
      end
    end
  end

  function automatic logic [16:0] act_res(input int i);
    return (i == 0) ? {c4, s4} : {8'h00, c2, s2};
  endfunction

  function automatic logic act_busy(input int i);
    return (i == 0) ? busy4 : busy2;
  endfunction

  function automatic logic act_done(input int i);
    return (i == 0) ? done4 : done2;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add4(input logic [15:0] a, input logic [15:0] b, input logic ci,
                      input bit intrude, input logic [15:0] es, input logic ec,
                      input string tag);
    int lat;
    int ndone;
    @(negedge clk);
    start[0] = 1'b1; op_a[0] = a; op_b[0] = b; cin[0] = ci;
    @(negedge clk);
    lat = 1;
    start[0] = intrude;
    op_a[0] = intrude ? 16'h1111 : 16'($urandom);
    op_b[0] = intrude ? 16'h1111 : 16'($urandom);
    cin[0]  = 1'($urandom_range(0, 1));
    while (!done4 && lat < 20) begin
      @(negedge clk);
      lat++;
      start[0] = 1'b0;
      op_a[0]  = 16'($urandom);
      op_b[0]  = 16'($urandom);
    end
    chk({tag, " latency"}, lat, 5);
    chk({tag, " sum"}, s4, es);
    chk({tag, " carry"}, c4, ec);
    ndone = 1;
    repeat (8) begin
      @(negedge clk);
      if (done4) ndone++;
    end
    chk({tag, " done pulses"}, ndone, 1);
  endtask

  initial begin
    int dt [$];
    int t;
    int got;
    int cyc;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; op_a[i] = '0; op_b[i] = '0; cin[i] = 1'b0;
    end

    fork
      forever begin
        @(negedge clk);
        if (chk_en && !rst) begin
          for (int i = 0; i < 2; i++) begin
            chk($sformatf("busy n%0d", nn(i)), act_busy(i), (age[i] >= 0 && age[i] < nn(i)));
            chk($sformatf("done n%0d", nn(i)), act_done(i), (age[i] == nn(i)));
            if (age[i] < 0 || age[i] == nn(i))
              chk($sformatf("result n%0d", nn(i)), act_res(i), held[i]);
          end
        end
      end
      begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
      end
    join_none

    repeat (2) @(negedge clk);
    chk("reset busy", busy4, 1'b0);
    chk("reset done", done4, 1'b0);
    chk("reset sum", {c4, s4}, 17'h0);
    #2 rst = 1'b0;
    chk_en = 1'b1;

    add4(16'h0002, 16'h0002, 1'b0, 1'b0, 16'h0004, 1'b0, "2+2");
    add4(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, "ripple");
    add4(16'h7777, 16'h7777, 1'b1, 1'b0, 16'hEEEF, 1'b0, "7777");
    add4(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, "all ones");
    add4(16'h000A, 16'h0005, 1'b0, 1'b1, 16'h000F, 1'b0, "start in ADD");

    // Asynchronous reset after nibble 1 of 0x1234+0x1111 (partial result 0x0045).
    @(negedge clk);
    start[0] = 1'b1; op_a[0] = 16'h1234; op_b[0] = 16'h1111; cin[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("mid-add reset busy", busy4, 1'b0);
    chk("mid-add reset done", done4, 1'b0);
    chk("mid-add reset sum", s4, 16'h0000);
    chk("mid-add reset carry", c4, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    add4(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, "after reset");

    // Start held high: one result every N+2 cycles.
    @(negedge clk);
    start[0] = 1'b1; op_a[0] = 16'h0101; op_b[0] = 16'h0202; cin[0] = 1'b1;
    t = 0;
    repeat (20) begin
      @(negedge clk);
      t++;
      if (done4) dt.push_back(t);
    end
    start[0] = 1'b0;
    chk("held start done count", dt.size(), 3);
    if (dt.size() == 3) begin
      chk("held start period 1", dt[1] - dt[0], 6);
      chk("held start period 2", dt[2] - dt[1], 6);
    end
    chk("held start sum", s4, 16'h0304);
    repeat (10) @(negedge clk);

    // Random sweep on the 2-nibble instance; every result is checked by the model.
    got = 0;
    cyc = 0;
    while (got < 1000 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (done2) got++;
      start[1] = ($urandom_range(0, 7) != 0);
      op_a[1]  = 16'($urandom);
      op_b[1]  = 16'($urandom);
      cin[1]   = 1'($urandom_range(0, 1));
    end
    start[1] = 1'b0;
    chk("sweep results", got, 1000);
    repeat (6) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
